// File: rtl/eth_rx_frame_gen.sv
// ---------------------------------------------------------------------------
// eth_rx_frame_gen
//
// Ethernet receive-stream source. Drives the 64-bit AXI-Stream RX interface
// that a 10G MAC would present to the adapter datapath (no tready). On start
// it emits frame_count frames of FRAME_LEN bytes. Each frame has a fixed
// DST/SRC/EtherType header followed by an incrementing payload that is seeded
// with the frame index. Idle gaps of IFG_CYCLES separate the frames.
//
// Ports:
//   eth_clk        in   1   stream clock
//   sys_rst_n      in   1   asynchronous active-low reset
//   start          in   1   one-cycle burst request (ignored while busy)
//   frame_count    in  16   frames in the burst, sampled with start (0 = ignore)
//   busy           out  1   burst in progress
//   done           out  1   one-cycle pulse after the final beat of the burst
//   frames_sent    out 16   frames completed in the current/last burst
//   eth_rx_tvalid  out  1   beat valid
//   eth_rx_tdata   out 64   beat data, byte k on [8k+7:8k]
//   eth_rx_tkeep   out  8   contiguous byte enables from bit 0
//   eth_rx_tlast   out  1   last beat of frame
//   eth_rx_tuser   out  1   on tlast: 1 = good frame, 0 = bad frame
// ---------------------------------------------------------------------------
module eth_rx_frame_gen #(
    parameter int unsigned FRAME_LEN  = 64,
    parameter int unsigned IFG_CYCLES = 3,
    parameter logic [47:0] DST_MAC    = 48'h02_00_00_00_00_01,
    parameter logic [47:0] SRC_MAC    = 48'h02_00_00_00_00_02,
    parameter logic [15:0] ETHERTYPE  = 16'h0800,
    parameter int unsigned BAD_EVERY  = 0
) (
    input  logic        eth_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [15:0] frame_count,
    output logic        busy,
    output logic        done,
    output logic [15:0] frames_sent,
    output logic        eth_rx_tvalid,
    output logic [63:0] eth_rx_tdata,
    output logic [7:0]  eth_rx_tkeep,
    output logic        eth_rx_tlast,
    output logic        eth_rx_tuser
);

    localparam int unsigned NBEATS    = (FRAME_LEN + 7) / 8;
    localparam logic [10:0] LAST_BEAT = 11'(NBEATS - 1);
    localparam logic [13:0] LEN_B     = 14'(FRAME_LEN);
    localparam int unsigned TAIL      = FRAME_LEN % 8;
    localparam logic [7:0]  LAST_KEEP = (TAIL == 0) ? 8'hFF : 8'((1 << TAIL) - 1);
    localparam logic [15:0] GAP_LOAD  = (IFG_CYCLES > 0) ? 16'(IFG_CYCLES - 1) : 16'd0;
    localparam int unsigned BAD_DIV   = (BAD_EVERY == 0) ? 1 : BAD_EVERY;
    localparam logic [111:0] HDR      = {DST_MAC, SRC_MAC, ETHERTYPE};

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] beat_q, beat_d;
    logic [15:0] gap_q, gap_d;
    logic [15:0] count_q, count_d;
    logic [15:0] sent_q, sent_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        tvalid_q, tvalid_d;
    logic [63:0] tdata_q, tdata_d;
    logic [7:0]  tkeep_q, tkeep_d;
    logic        tlast_q, tlast_d;
    logic        tuser_q, tuser_d;

    // Beat contents for frame index f (low byte only matters) and beat b.
    // Bytes past FRAME_LEN are forced to zero.
    function automatic logic [63:0] beat_data(input logic [7:0] f8, input logic [10:0] b);
        logic [63:0] d;
        logic [13:0] idx;
        logic [3:0]  hsel;
        d = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            idx = {b, 3'b000} + 14'(k);
            if (idx < 14'd14) begin
                // Header is stored MSB-first: byte 0 sits in HDR[111:104].
                hsel = 4'd13 - idx[3:0];
                d[8*k +: 8] = 8'(HDR >> {hsel, 3'b000});
            end else if (idx < LEN_B) begin
                d[8*k +: 8] = f8 + idx[7:0] - 8'd14;
            end
        end
        return d;
    endfunction

    function automatic logic is_bad(input logic [15:0] f);
        return (BAD_EVERY != 0) && (((32'(f) + 32'd1) % BAD_DIV) == 0);
    endfunction

    logic        load;
    logic [15:0] f_n;
    logic [10:0] b_n;
    logic [15:0] sent_inc;
    logic        last_n;

    assign sent_inc = sent_q + 16'd1;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        gap_d    = gap_q;
        count_d  = count_q;
        sent_d   = sent_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        tvalid_d = 1'b0;
        tdata_d  = '0;
        tkeep_d  = '0;
        tlast_d  = 1'b0;
        tuser_d  = 1'b0;
        load     = 1'b0;
        f_n      = sent_q;
        b_n      = '0;
        last_n   = 1'b0;

        // The output registers always hold the beat being presented, so each
        // branch decides what the *next* cycle shows and requests a load.
        case (state_q)
            S_IDLE: begin
                if (start && (frame_count != 16'd0)) begin
                    count_d = frame_count;
                    sent_d  = '0;
                    busy_d  = 1'b1;
                    state_d = S_SEND;
                    load    = 1'b1;
                    f_n     = '0;
                end
            end
            S_SEND: begin
                if (beat_q != LAST_BEAT) begin
                    load = 1'b1;
                    b_n  = beat_q + 11'd1;
                end else begin
                    sent_d = sent_inc;
                    if (sent_inc == count_q) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (IFG_CYCLES > 0) begin
                        state_d = S_GAP;
                        gap_d   = GAP_LOAD;
                    end else begin
                        load = 1'b1;
                        f_n  = sent_inc;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == 16'd0) begin
                    state_d = S_SEND;
                    load    = 1'b1;
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (load) begin
            last_n   = (b_n == LAST_BEAT);
            beat_d   = b_n;
            tvalid_d = 1'b1;
            tdata_d  = beat_data(f_n[7:0], b_n);
            tkeep_d  = last_n ? LAST_KEEP : 8'hFF;
            tlast_d  = last_n;
            tuser_d  = last_n && !is_bad(f_n);
        end
    end

    always_ff @(posedge eth_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= S_IDLE;
            beat_q   <= '0;
            gap_q    <= '0;
            count_q  <= '0;
            sent_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            gap_q    <= gap_d;
            count_q  <= count_d;
            sent_q   <= sent_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign frames_sent   = sent_q;
    assign eth_rx_tvalid = tvalid_q;
    assign eth_rx_tdata  = tdata_q;
    assign eth_rx_tkeep  = tkeep_q;
    assign eth_rx_tlast  = tlast_q;
    assign eth_rx_tuser  = tuser_q;

endmodule

// File: tb/tb_eth_rx_frame_gen.sv
// ---------------------------------------------------------------------------
// tb_eth_rx_frame_gen
//
// Directed bench for eth_rx_frame_gen. Four instances cover the parameter
// variants: defaults, FRAME_LEN=60, BAD_EVERY=2 and IFG_CYCLES=0. Expected
// values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_eth_rx_frame_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_r  [4];
    logic [15:0] fc_r     [4];
    logic        busy_w   [4];
    logic        done_w   [4];
    logic [15:0] sent_w   [4];
    logic        tvalid_w [4];
    logic [63:0] tdata_w  [4];
    logic [7:0]  tkeep_w  [4];
    logic        tlast_w  [4];
    logic        tuser_w  [4];

    eth_rx_frame_gen u_def (
        .eth_clk(clk), .sys_rst_n(rst_n), .start(start_r[0]), .frame_count(fc_r[0]),
        .busy(busy_w[0]), .done(done_w[0]), .frames_sent(sent_w[0]),
        .eth_rx_tvalid(tvalid_w[0]), .eth_rx_tdata(tdata_w[0]), .eth_rx_tkeep(tkeep_w[0]),
        .eth_rx_tlast(tlast_w[0]), .eth_rx_tuser(tuser_w[0])
    );

    eth_rx_frame_gen #(.FRAME_LEN(60)) u_60 (
        .eth_clk(clk), .sys_rst_n(rst_n), .start(start_r[1]), .frame_count(fc_r[1]),
        .busy(busy_w[1]), .done(done_w[1]), .frames_sent(sent_w[1]),
        .eth_rx_tvalid(tvalid_w[1]), .eth_rx_tdata(tdata_w[1]), .eth_rx_tkeep(tkeep_w[1]),
        .eth_rx_tlast(tlast_w[1]), .eth_rx_tuser(tuser_w[1])
    );

    eth_rx_frame_gen #(.BAD_EVERY(2)) u_bad (
        .eth_clk(clk), .sys_rst_n(rst_n), .start(start_r[2]), .frame_count(fc_r[2]),
        .busy(busy_w[2]), .done(done_w[2]), .frames_sent(sent_w[2]),
        .eth_rx_tvalid(tvalid_w[2]), .eth_rx_tdata(tdata_w[2]), .eth_rx_tkeep(tkeep_w[2]),
        .eth_rx_tlast(tlast_w[2]), .eth_rx_tuser(tuser_w[2])
    );

    eth_rx_frame_gen #(.IFG_CYCLES(0)) u_b2b (
        .eth_clk(clk), .sys_rst_n(rst_n), .start(start_r[3]), .frame_count(fc_r[3]),
        .busy(busy_w[3]), .done(done_w[3]), .frames_sent(sent_w[3]),
        .eth_rx_tvalid(tvalid_w[3]), .eth_rx_tdata(tdata_w[3]), .eth_rx_tkeep(tkeep_w[3]),
        .eth_rx_tlast(tlast_w[3]), .eth_rx_tuser(tuser_w[3])
    );

    int vectors    = 0;
    int miscompares = 0;

    // Burst capture results
    logic [63:0] beats_q  [$];
    logic [7:0]  keeps_q  [$];
    logic        tusers_q [$];
    int          gaps_q   [$];
    int          lat, maxrun, done_cnt, done_gap, ntlast, dirty;
    logic [15:0] sent_at_done, sent_at_last;
    logic        busy_at_done, done_seen;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on instance d and record the stream until three cycles
    // after done, or until the cycle budget runs out.
    task automatic burst(input int d, input logic [15:0] n, input int budget);
        int   cyc, run, idle, last_cyc, done_cyc;
        logic in_gap;
        beats_q.delete(); keeps_q.delete(); tusers_q.delete(); gaps_q.delete();
        lat = -1; maxrun = 0; done_cnt = 0; done_gap = -1; ntlast = 0; dirty = 0;
        sent_at_done = '1; sent_at_last = '1; busy_at_done = 1'b1;
        run = 0; idle = 0; in_gap = 1'b0; last_cyc = -1; done_cyc = -1;
        start_r[d] = 1'b1;
        fc_r[d]    = n;
        tick();
        start_r[d] = 1'b0;
        fc_r[d]    = '0;
        cyc = 1;
        while (cyc <= budget && (done_cyc < 0 || cyc <= done_cyc + 3)) begin
            if (tvalid_w[d]) begin
                if (lat < 0) lat = cyc;
                if (in_gap) begin
                    gaps_q.push_back(idle);
                    in_gap = 1'b0;
                end
                run++;
                if (run > maxrun) maxrun = run;
                beats_q.push_back(tdata_w[d]);
                keeps_q.push_back(tkeep_w[d]);
                if (tlast_w[d]) begin
                    ntlast++;
                    if (ntlast == 1) sent_at_last = sent_w[d];
                    tusers_q.push_back(tuser_w[d]);
                    last_cyc = cyc;
                    in_gap   = 1'b1;
                    idle     = 0;
                end else if (tuser_w[d]) begin
                    dirty++;
                end
            end else begin
                run = 0;
                idle++;
                if (tdata_w[d] != '0 || tkeep_w[d] != '0 || tlast_w[d] || tuser_w[d]) dirty++;
            end
            if (done_w[d]) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc     = cyc;
                    done_gap     = cyc - last_cyc;
                    sent_at_done = sent_w[d];
                    busy_at_done = busy_w[d];
                end
            end
            tick();
            cyc++;
        end
        done_seen = (done_cyc >= 0);
    endtask

    initial begin
        logic [63:0] tmp;
        logic [3:0]  tu;
        int          wait_cyc;

        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            start_r[i] = 1'b0;
            fc_r[i]    = '0;
        end

        // Reset state on every instance
        #12;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rst_ctl%0d", d),
                64'({busy_w[d], done_w[d], sent_w[d], tvalid_w[d], tlast_w[d], tuser_w[d], tkeep_w[d]}),
                64'd0);
            chk($sformatf("rst_data%0d", d), tdata_w[d], 64'd0);
        end
        #1 rst_n = 1'b1;
        tick();
        tick();

        // Defaults, one frame of 64 bytes
        burst(0, 16'd1, 60);
        chk("A_done_seen", 64'(done_seen), 64'd1);
        chk("A_latency",   64'(lat), 64'd1);
        chk("A_nbeats",    64'(beats_q.size()), 64'd8);
        chk("A_beat0",     beats_q[0], 64'h0002_0100_0000_0002);
        chk("A_beat1",     beats_q[1], 64'h0100_0008_0200_0000);
        chk("A_beat7",     beats_q[7], 64'h3130_2F2E_2D2C_2B2A);
        chk("A_keep7",     64'(keeps_q[7]), 64'hFF);
        chk("A_ntlast",    64'(ntlast), 64'd1);
        chk("A_tuser",     64'(tusers_q[0]), 64'd1);
        chk("A_sent_on_last", 64'(sent_at_last), 64'd0);
        chk("A_done_gap",  64'(done_gap), 64'd1);
        chk("A_done_cnt",  64'(done_cnt), 64'd1);
        chk("A_sent",      64'(sent_at_done), 64'd1);
        chk("A_busy_at_done", 64'(busy_at_done), 64'd0);
        chk("A_dirty",     64'(dirty), 64'd0);

        // FRAME_LEN=60: short last beat
        burst(1, 16'd1, 60);
        chk("B_done_seen", 64'(done_seen), 64'd1);
        chk("B_nbeats",    64'(beats_q.size()), 64'd8);
        chk("B_keep0",     64'(keeps_q[0]), 64'hFF);
        chk("B_keep7",     64'(keeps_q[7]), 64'h0F);
        chk("B_beat7",     beats_q[7], 64'h0000_0000_2D2C_2B2A);
        tmp = beats_q[1];
        chk("B_byte14",    64'(tmp[55:48]), 64'h00);
        chk("B_tuser",     64'(tusers_q[0]), 64'd1);
        chk("B_dirty",     64'(dirty), 64'd0);

        // Three frames with the default 3-cycle gap
        burst(0, 16'd3, 200);
        chk("C_done_seen", 64'(done_seen), 64'd1);
        chk("C_ntlast",    64'(ntlast), 64'd3);
        chk("C_nbeats",    64'(beats_q.size()), 64'd24);
        chk("C_ngaps",     64'(gaps_q.size()), 64'd2);
        chk("C_gap0",      64'(gaps_q[0]), 64'd3);
        chk("C_gap1",      64'(gaps_q[1]), 64'd3);
        tmp = beats_q[17];
        chk("C_f2_byte14", 64'(tmp[55:48]), 64'h02);
        chk("C_f2_beat7",  beats_q[23], 64'h3332_3130_2F2E_2D2C);
        chk("C_done_cnt",  64'(done_cnt), 64'd1);
        chk("C_done_gap",  64'(done_gap), 64'd1);
        chk("C_sent",      64'(sent_at_done), 64'd3);
        chk("C_dirty",     64'(dirty), 64'd0);

        // BAD_EVERY=2: every second frame flagged bad
        burst(2, 16'd4, 200);
        chk("D_done_seen", 64'(done_seen), 64'd1);
        chk("D_ntuser",    64'(tusers_q.size()), 64'd4);
        tu = {tusers_q[0], tusers_q[1], tusers_q[2], tusers_q[3]};
        chk("D_tuser_seq", 64'(tu), 64'b1010);
        chk("D_sent",      64'(sent_at_done), 64'd4);
        chk("D_dirty",     64'(dirty), 64'd0);

        // IFG_CYCLES=0: two frames back to back
        burst(3, 16'd2, 100);
        chk("E_done_seen", 64'(done_seen), 64'd1);
        chk("E_maxrun",    64'(maxrun), 64'd16);
        chk("E_gap0",      64'(gaps_q[0]), 64'd0);
        chk("E_ntlast",    64'(ntlast), 64'd2);
        chk("E_f1_beat0",  beats_q[8], 64'h0002_0100_0000_0002);
        tmp = beats_q[9];
        chk("E_f1_byte14", 64'(tmp[55:48]), 64'h01);
        chk("E_done_gap",  64'(done_gap), 64'd1);
        chk("E_sent",      64'(sent_at_done), 64'd2);

        // Reset during beat 3 of the second frame
        start_r[0] = 1'b1;
        fc_r[0]    = 16'd2;
        tick();
        start_r[0] = 1'b0;
        fc_r[0]    = '0;
        repeat (14) tick();
        chk("F_pre_valid", 64'(tvalid_w[0]), 64'd1);
        chk("F_pre_data",  tdata_w[0], 64'h1211_100F_0E0D_0C0B);
        chk("F_pre_last",  64'(tlast_w[0]), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("F_rst_ctl",
            64'({busy_w[0], done_w[0], sent_w[0], tvalid_w[0], tlast_w[0], tuser_w[0], tkeep_w[0]}),
            64'd0);
        chk("F_rst_data", tdata_w[0], 64'd0);
        #2 rst_n = 1'b1;
        tick();
        chk("F_post_idle", 64'({busy_w[0], tvalid_w[0], tlast_w[0], sent_w[0]}), 64'd0);

        // start with frame_count=0 is ignored
        start_r[0] = 1'b1;
        fc_r[0]    = 16'd0;
        tick();
        start_r[0] = 1'b0;
        chk("F_zero_busy",  64'(busy_w[0]), 64'd0);
        chk("F_zero_valid", 64'(tvalid_w[0]), 64'd0);
        tick();
        chk("F_zero_valid2", 64'(tvalid_w[0]), 64'd0);

        // start while busy does not alter the burst
        start_r[0] = 1'b1;
        fc_r[0]    = 16'd2;
        tick();
        start_r[0] = 1'b0;
        fc_r[0]    = '0;
        repeat (4) tick();
        start_r[0] = 1'b1;
        fc_r[0]    = 16'd5;
        tick();
        start_r[0] = 1'b0;
        fc_r[0]    = '0;
        wait_cyc = 0;
        while (!done_w[0] && wait_cyc < 100) begin
            tick();
            wait_cyc++;
        end
        chk("G_done_seen", 64'(done_w[0]), 64'd1);
        chk("G_sent",      64'(sent_w[0]), 64'd2);
        repeat (3) tick();
        chk("G_sent_hold", 64'(sent_w[0]), 64'd2);
        chk("G_idle",      64'({busy_w[0], tvalid_w[0]}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/eth_rx_frame_gen.md
Name: eth_rx_frame_gen

Overview:
Synthesizable Ethernet receive-stream source. It drives the 64-bit AXI-Stream RX interface that the 10G MAC presents to the adapter datapath: tvalid/tdata/tkeep/tlast/tuser, with no tready. It emits a programmed number of frames with deterministic headers and payload, so benches and on-board loopback tests can exercise the adapter RX path without a PHY.

Parameters:
FRAME_LEN, 64, frame length in bytes excluding FCS; legal range 14..16383.
IFG_CYCLES, 3, idle cycles (tvalid=0) between consecutive frames; 0 means back-to-back.
DST_MAC, 48'h02_00_00_00_00_01, destination MAC placed in bytes 0..5, MSB first.
SRC_MAC, 48'h02_00_00_00_00_02, source MAC placed in bytes 6..11, MSB first.
ETHERTYPE, 16'h0800, placed in bytes 12..13, big-endian.
BAD_EVERY, 0, mark every Nth frame bad (tuser=0 on tlast); 0 means never.

Ports:
eth_clk  input  1  stream clock.
sys_rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to begin a burst.
frame_count  input  16  number of frames in the burst; sampled with start.
busy  output  1  high from accepted start until the final beat of the burst.
done  output  1  one-cycle pulse after the final beat of the burst.
frames_sent  output  16  frames completed in the current or last burst.
eth_rx_tvalid  output  1  beat valid.
eth_rx_tdata  output  64  data; byte k of a beat is on [8k+7:8k].
eth_rx_tkeep  output  8  byte enables, contiguous from bit 0.
eth_rx_tlast  output  1  last beat of frame.
eth_rx_tuser  output  1  on the tlast beat: 1 = good frame, 0 = bad frame.

Behaviour:
- Reset (asynchronous, sys_rst_n=0): state IDLE. All outputs 0: busy, done, frames_sent, tvalid, tdata, tkeep, tlast, tuser. Asserting reset mid-frame truncates the frame immediately, with no tlast. After release, the block waits for a new start.
- FSM states IDLE, SEND, GAP. All outputs are registered.
- IDLE: start=1 with frame_count!=0 latches the count, clears frames_sent, sets busy and moves to SEND. The first beat appears the next cycle, so start-to-tvalid latency is 1 cycle. start with frame_count=0 is ignored.
- start while busy is ignored; the burst continues unchanged.
- SEND: tvalid=1 for every beat of the frame with no bubbles. Beats per frame = ceil(FRAME_LEN/8).
- Frame byte i (0-based) is:
  - i<6: DST_MAC byte, MSB first;
  - 6..11: SRC_MAC byte;
  - 12..13: ETHERTYPE, high byte first;
  - i>=14: (f + i - 14) mod 256, where f is the 0-based frame index within the burst, modulo 256.
- tkeep = 8'hFF on non-last beats. On the last beat, r = FRAME_LEN mod 8; tkeep = (1<<r)-1, or 8'hFF when r=0. Bytes beyond tkeep read 0.
- tlast=1 only on the last beat. tuser=0 on non-last beats. On the last beat tuser=0 if BAD_EVERY!=0 and (f+1) mod BAD_EVERY == 0; otherwise tuser=1.
- frames_sent increments on each last beat; its value is visible the cycle after.
- After the last beat:
  - if frames remain and IFG_CYCLES>0: GAP for exactly IFG_CYCLES cycles, then SEND;
  - if frames remain and IFG_CYCLES=0: the next frame's first beat follows in the next cycle;
  - if no frames remain: IDLE, busy=0 and done=1 for one cycle, both in the cycle after the last beat.
- Whenever tvalid=0, tdata, tkeep, tlast and tuser are 0.
- Counters: the beat counter is 11 bits and the frame counter 16 bits. frame_count=65535 completes without wrap; frames_sent saturates at no value because it cannot exceed frame_count.

Test Plan:
- Defaults, start with frame_count=1: 8 beats. Beat 0 tdata = 64'h0100_0000_0002_0000 is wrong order, so check bytes: byte0..5 = 02 00 00 00 00 01, byte6..7 = 02 00. Beat 7 has tlast=1, tkeep=8'hFF, tuser=1. Then done pulse, frames_sent=1.
- FRAME_LEN=60, one frame: 8 beats, last beat tkeep=8'h0F. Byte 14 = 8'h00 and byte 59 = 8'h2D.
- frame_count=3, IFG_CYCLES=3: exactly 3 tvalid=0 cycles between frames. Frame 2 byte 14 = 8'h02. done appears once, 1 cycle after the third tlast.
- BAD_EVERY=2, frame_count=4: tuser on tlast reads 1,0,1,0. frames_sent=4.
- IFG_CYCLES=0, frame_count=2: tvalid stays high across the frame boundary for 16 consecutive cycles.
- Negate sys_rst_n during beat 3 of frame 1: all outputs 0 in the same cycle, no tlast. A start with frame_count=0 after release is ignored. start issued while busy does not change frames_sent's final value.
